// File: rtl/sender_pkg.sv
// Shared definitions for the sender arbiter: FSM state encoding and default sizing.
package sender_pkg;

  // FSM states of the arbiter; encoding is visible on the debug state output.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACC  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  // Width of the sender's DataIn word.
  localparam int DATA_W_DEF  = 16;
  // Cycles the sender may ignore Transmit before the request is aborted.
  localparam int ACC_TMO_DEF = 15;
  // Width of the acceptance timeout counter.
  localparam int TMO_W       = 4;

endpackage

// File: rtl/sender_arbiter_rr_pick.sv
// Round-robin winner selection: first set request bit at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan N positions starting at ptr; the first requester found wins.
  always_comb begin
    int j;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/sender_arbiter.sv
// Shares one handshake sender among N_CLIENTS requesters. A round-robin winner's
// word is captured, the sender is driven through one Transmit/accept/Ack cycle,
// and the client gets a one-cycle done pulse (or err pulse if never accepted).
//
// Handshake: a client holds cli_req high until it sees its cli_done or cli_err
// bit; the sender accepts Transmit by dropping sdr_ready and signals completion
// by raising sdr_ready again. All outputs are registered.
module sender_arbiter
  import sender_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_TMO   = ACC_TMO_DEF,
  parameter int IW        = $clog2(N_CLIENTS)
) (
  input  logic                          clk,
  input  logic                          Reset,
  input  logic [N_CLIENTS-1:0]          cli_req,
  input  logic [N_CLIENTS*DATA_W-1:0]   cli_data,
  output logic [N_CLIENTS-1:0]          cli_done,
  output logic [N_CLIENTS-1:0]          cli_err,
  input  logic                          sdr_ready,
  output logic                          sdr_transmit,
  output logic [DATA_W-1:0]             sdr_data,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(ACC_TMO);

  state_e                 state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          grant_q, grant_d;
  logic                   tx_q, tx_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [N_CLIENTS-1:0]   done_q, done_d;
  logic [N_CLIENTS-1:0]   err_q, err_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;

  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic [TMO_W-1:0]       tmo_inc;
  logic [IW-1:0]          ptr_after_grant;

  rr_pick #(
    .N  (N_CLIENTS),
    .IW (IW)
  ) u_rr_pick (
    .req   (cli_req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign tmo_inc = tmo_q + 1'b1;

  // Pointer moves one past the client just served, wrapping at N_CLIENTS-1.
  always_comb begin
    if (grant_q == IW'(N_CLIENTS - 1)) ptr_after_grant = '0;
    else                               ptr_after_grant = grant_q + 1'b1;
  end

  // Next-state and registered-output logic of the transfer sequencer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    tx_d     = tx_q;
    data_d   = data_q;
    tmo_d    = tmo_q;
    done_d   = '0;
    err_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid && sdr_ready) begin
          grant_d = pick_idx;
          data_d  = cli_data[int'(pick_idx)*DATA_W +: DATA_W];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tx_d    = 1'b1;
        tmo_d   = '0;
        state_d = ST_WAIT_ACC;
      end
      ST_WAIT_ACC: begin
        if (!sdr_ready) begin
          // Sender dropped Ready: it has taken the word.
          tx_d    = 1'b0;
          state_d = ST_WAIT_DONE;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_LIM) begin
            tx_d            = 1'b0;
            err_d[grant_q]  = 1'b1;
            rr_ptr_d        = ptr_after_grant;
            state_d         = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        // No timeout here: the Ack path belongs to the client system.
        if (sdr_ready) begin
          done_d[grant_q] = 1'b1;
          rr_ptr_d        = ptr_after_grant;
          state_d         = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      tx_q     <= 1'b0;
      data_q   <= '0;
      done_q   <= '0;
      err_q    <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      tx_q     <= tx_d;
      data_q   <= data_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign cli_done     = done_q;
  assign cli_err      = err_q;
  assign sdr_transmit = tx_q;
  assign sdr_data     = data_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q != ST_IDLE);
  assign dbg_state    = state_q;

endmodule
